// File: rtl/flappy_pkg.sv
// Shared Flappy-VGA definitions: screen geometry, game state encodings and
// the pseudo-random generator seed/feedback mask.
package flappy_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // One-hot game states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_SCROLL = 3'b010,
      ST_FROZEN = 3'b100
   } state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pipe_lfsr.sv
// 16-bit Galois LFSR with synchronous reset to the shared seed. The advance
// enable lets other blocks step it at their own rate; the low byte is exported.
module pipe_lfsr
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       advance,
   output logic [7:0] rand_byte
);

   logic [15:0] state;

   // Shift right; when the bit falling out is 1, fold the feedback mask back in
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LFSR_SEED;
      end else if (advance) begin
         if (state[0]) state <= (state >> 1) ^ LFSR_TAPS;
         else          state <= state >> 1;
      end
   end

   assign rand_byte = state[7:0];

endmodule

// File: rtl/pipe_generator.sv
// Scrolling pipe obstacle for Flappy-VGA: drives the pipe edges, validity and
// score. Define PIPE_SPEEDUP_EN to make the scroll step grow with the score
// (1 px/tick plus 1 per 8 points, capped at 4); otherwise the step is 1 px.
module pipe_generator
   import flappy_pkg::*;
#(
   parameter int SCREEN_W   = flappy_pkg::SCREEN_W,
   parameter int PIPE_W     = 60,
   parameter int GAP_H      = 120,
   parameter int GAP_MIN    = 40,
   parameter int GAP_SPAN   = 200,
   parameter int SCROLL_DIV = 400000,
   parameter int BIRD_X     = 200
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       Q_Lose,
   input  logic       Ack,
   output logic [9:0] X_Edge_Left,
   output logic [9:0] X_Edge_Right,
   output logic [9:0] Y_Edge_Top,
   output logic [9:0] Y_Edge_Bottom,
   output logic       Pipe_Valid,
   output logic [7:0] Score
);

   localparam int DIV_W = (SCROLL_DIV > 2) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
   localparam logic [9:0] SPAWN_X = 10'(SCREEN_W + PIPE_W);

   state_t           state;
   logic [DIV_W-1:0] divider;
   logic             scored;
   logic [7:0]       rand_byte;

   logic [9:0]       step;
   logic [9:0]       moved_x;
   logic             respawn;
   logic             tick;
   logic [9:0]       spawn_top;
   logic [9:0]       spawn_bottom;

   // Gap top from a random byte: fold values above the span back into range
   function automatic logic [9:0] gap_top(input logic [7:0] r);
      logic [8:0] off;
      off = {1'b0, r};
      if (off > 9'(GAP_SPAN)) off = off - 9'(GAP_SPAN);
      return 10'(GAP_MIN) + {1'b0, off};
   endfunction

   // Left edge saturates at column 0 while the pipe slides off-screen
   function automatic logic [9:0] left_edge(input logic [9:0] x);
      return (x < 10'(PIPE_W)) ? 10'd0 : x - 10'(PIPE_W);
   endfunction

   // Score counter saturates at 255
   function automatic logic [7:0] sat_inc(input logic [7:0] s);
      return (s == 8'hFF) ? s : s + 8'd1;
   endfunction

   pipe_lfsr u_lfsr (
      .clk       (Clk),
      .reset     (reset),
      .advance   (1'b1),
      .rand_byte (rand_byte)
   );

`ifdef PIPE_SPEEDUP_EN
   // Step grows by one for every 8 points, capped at 4 px per tick
   always_comb begin
      step = 10'd1;
      if (Score[7:3] > 5'd3) step = 10'd4;
      else                   step = 10'd1 + {5'd0, Score[7:3]};
   end
`else
   assign step = 10'd1;
`endif

   // Next-move candidates; a lose indication in the tick cycle suppresses the move
   always_comb begin
      moved_x      = X_Edge_Right - step;
      respawn      = (X_Edge_Right <= step);
      tick         = (state == ST_SCROLL) && (divider == DIV_LAST) && !Q_Lose;
      spawn_top    = gap_top(rand_byte);
      spawn_bottom = spawn_top + 10'(GAP_H);
   end

   // Game FSM together with pipe position, gap, divider and score registers
   always_ff @(posedge Clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         divider       <= '0;
         scored        <= 1'b0;
         Score         <= 8'd0;
         Pipe_Valid    <= 1'b0;
         X_Edge_Left   <= 10'd0;
         X_Edge_Right  <= 10'd0;
         Y_Edge_Top    <= 10'd0;
         Y_Edge_Bottom <= 10'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  state         <= ST_SCROLL;
                  divider       <= '0;
                  scored        <= 1'b0;
                  Score         <= 8'd0;
                  Pipe_Valid    <= 1'b1;
                  X_Edge_Right  <= SPAWN_X;
                  X_Edge_Left   <= left_edge(SPAWN_X);
                  Y_Edge_Top    <= spawn_top;
                  Y_Edge_Bottom <= spawn_bottom;
               end
            end
            ST_SCROLL: begin
               if (Q_Lose) begin
                  state <= ST_FROZEN;
               end else begin
                  divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
                  if (tick) begin
                     if (respawn) begin
                        scored        <= 1'b0;
                        X_Edge_Right  <= SPAWN_X;
                        X_Edge_Left   <= left_edge(SPAWN_X);
                        Y_Edge_Top    <= spawn_top;
                        Y_Edge_Bottom <= spawn_bottom;
                     end else begin
                        X_Edge_Right <= moved_x;
                        X_Edge_Left  <= left_edge(moved_x);
                        if (!scored && (moved_x < 10'(BIRD_X))) begin
                           Score  <= sat_inc(Score);
                           scored <= 1'b1;
                        end
                     end
                  end
               end
            end
            ST_FROZEN: begin
               if (Ack) begin
                  state         <= ST_IDLE;
                  Pipe_Valid    <= 1'b0;
                  X_Edge_Left   <= 10'd0;
                  X_Edge_Right  <= 10'd0;
                  Y_Edge_Top    <= 10'd0;
                  Y_Edge_Bottom <= 10'd0;
               end
            end
            default: begin
               state         <= ST_IDLE;
               Pipe_Valid    <= 1'b0;
               X_Edge_Left   <= 10'd0;
               X_Edge_Right  <= 10'd0;
               Y_Edge_Top    <= 10'd0;
               Y_Edge_Bottom <= 10'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator: two instances share stimulus, one with a
// 4-cycle scroll divider and one with a 2-cycle divider.
module tb_pipe_generator;

   logic       Clk;
   logic       reset;
   logic       Start;
   logic       Q_Lose;
   logic       Ack;

   logic [9:0] d2_xl, d2_xr, d2_yt, d2_yb;
   logic       d2_valid;
   logic [7:0] d2_score;
   logic [9:0] d4_xl, d4_xr, d4_yt, d4_yb;
   logic       d4_valid;
   logic [7:0] d4_score;

   logic [15:0] m_lfsr;
   int checks;
   int failures;

   pipe_generator #(.SCROLL_DIV(2)) dut2 (
      .Clk(Clk), .reset(reset), .Start(Start), .Q_Lose(Q_Lose), .Ack(Ack),
      .X_Edge_Left(d2_xl), .X_Edge_Right(d2_xr), .Y_Edge_Top(d2_yt),
      .Y_Edge_Bottom(d2_yb), .Pipe_Valid(d2_valid), .Score(d2_score)
   );

   pipe_generator #(.SCROLL_DIV(4)) dut4 (
      .Clk(Clk), .reset(reset), .Start(Start), .Q_Lose(Q_Lose), .Ack(Ack),
      .X_Edge_Left(d4_xl), .X_Edge_Right(d4_xr), .Y_Edge_Top(d4_yt),
      .Y_Edge_Bottom(d4_yb), .Pipe_Valid(d4_valid), .Score(d4_score)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic logic [9:0] exp_top(input logic [15:0] v);
      int off;
      off = int'(v[7:0]);
      if (off > 200) off = off - 200;
      return 10'(40 + off);
   endfunction

   // Reference LFSR, reset and advanced exactly like the generator's
   always @(posedge Clk) begin
      if (reset) m_lfsr <= 16'hACE1;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic wait_x(input logic [9:0] target, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (d2_xr == target) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_x timeout got=%0d want=%0d", d2_xr, target);
      end
   endtask

   task automatic wait_move(input int budget, output logic [15:0] lfsr_before);
      logic [9:0] old;
      logic       moved;
      moved = 1'b0;
      lfsr_before = m_lfsr;
      for (int i = 0; i < budget; i++) begin
         old = d2_xr;
         lfsr_before = m_lfsr;
         cyc();
         if (d2_xr != old) begin
            moved = 1'b1;
            break;
         end
      end
      checks++;
      if (!moved) begin
         failures++;
         $display("FAIL wait_move timeout x=%0d", d2_xr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b0; Q_Lose = 1'b0; Ack = 1'b0;
      cyc(); cyc();
      reset = 1'b0;
      checks++; if (d2_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", d2_valid); end
      checks++; if (d2_xr !== 10'd0 || d2_xl !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d/%0d exp=0/0", d2_xl, d2_xr); end
      checks++; if (d2_yt !== 10'd0 || d2_yb !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d/%0d exp=0/0", d2_yt, d2_yb); end
      checks++; if (d2_score !== 8'd0 || d4_score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", d2_score); end
      checks++; if (d4_valid !== 1'b0) begin failures++; $display("FAIL reset_valid4 got=%0b exp=0", d4_valid); end
      cyc(); cyc(); cyc();
      checks++; if (dut2.u_lfsr.state === 16'hACE1) begin failures++; $display("FAIL lfsr_runs got=%h exp!=ace1", dut2.u_lfsr.state); end
      checks++; if (dut2.u_lfsr.state !== m_lfsr) begin failures++; $display("FAIL lfsr_value got=%h exp=%h", dut2.u_lfsr.state, m_lfsr); end
   endtask

   task automatic test_spawn();
      logic [9:0] top;
      top = exp_top(m_lfsr);
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      checks++; if (d4_xr !== 10'd700) begin failures++; $display("FAIL spawn_right got=%0d exp=700", d4_xr); end
      checks++; if (d4_xl !== 10'd640) begin failures++; $display("FAIL spawn_left got=%0d exp=640", d4_xl); end
      checks++; if (d4_yt !== top) begin failures++; $display("FAIL spawn_top got=%0d exp=%0d", d4_yt, top); end
      checks++; if (d4_yt < 10'd40 || d4_yt > 10'd240) begin failures++; $display("FAIL spawn_top_range got=%0d exp=40..240", d4_yt); end
      checks++; if (d4_yb !== top + 10'd120) begin failures++; $display("FAIL spawn_bottom got=%0d exp=%0d", d4_yb, top + 10'd120); end
      checks++; if (d4_valid !== 1'b1 || d2_valid !== 1'b1) begin failures++; $display("FAIL spawn_valid got=%0b/%0b exp=1/1", d4_valid, d2_valid); end
      checks++; if (d2_xr !== 10'd700) begin failures++; $display("FAIL spawn_right2 got=%0d exp=700", d2_xr); end
      cyc();
      checks++; if (d2_xr !== 10'd700) begin failures++; $display("FAIL div2_hold got=%0d exp=700", d2_xr); end
      cyc();
      checks++; if (d2_xr !== 10'd699) begin failures++; $display("FAIL div2_tick got=%0d exp=699", d2_xr); end
      cyc();
      checks++; if (d4_xr !== 10'd700) begin failures++; $display("FAIL div4_hold got=%0d exp=700", d4_xr); end
      cyc();
      checks++; if (d4_xr !== 10'd699) begin failures++; $display("FAIL div4_tick got=%0d exp=699", d4_xr); end
      checks++; if (d2_xr !== 10'd698) begin failures++; $display("FAIL div2_tick2 got=%0d exp=698", d2_xr); end
   endtask

   task automatic test_ignored_in_scroll();
      Ack = 1'b1; Start = 1'b1;
      cyc();
      Ack = 1'b0; Start = 1'b0;
      checks++; if (d2_valid !== 1'b1) begin failures++; $display("FAIL ack_in_scroll valid got=%0b exp=1", d2_valid); end
      checks++; if (d2_xr > 10'd698) begin failures++; $display("FAIL start_in_scroll x got=%0d exp<=698", d2_xr); end
   endtask

   task automatic test_score_and_edges();
      logic       ok;
      logic [15:0] lb;
      logic [9:0]  top;
      wait_x(10'd200, 3000, ok);
      checks++; if (d2_score !== 8'd0) begin failures++; $display("FAIL score_before got=%0d exp=0", d2_score); end
      wait_move(4, lb);
      checks++; if (d2_xr !== 10'd199 || d2_score !== 8'd1) begin failures++; $display("FAIL score_cross got=x%0d/s%0d exp=x199/s1", d2_xr, d2_score); end
      wait_x(10'd61, 400, ok);
      checks++; if (d2_xl !== 10'd1) begin failures++; $display("FAIL left_61 got=%0d exp=1", d2_xl); end
      wait_x(10'd59, 8, ok);
      checks++; if (d2_xl !== 10'd0) begin failures++; $display("FAIL left_clamp got=%0d exp=0", d2_xl); end
      wait_x(10'd1, 200, ok);
      wait_move(4, lb);
      top = exp_top(lb);
      checks++; if (d2_xr !== 10'd700 || d2_xl !== 10'd640) begin failures++; $display("FAIL respawn_x got=%0d/%0d exp=640/700", d2_xl, d2_xr); end
      checks++; if (d2_yt !== top || d2_yb !== top + 10'd120) begin failures++; $display("FAIL respawn_gap got=%0d/%0d exp=%0d/%0d", d2_yt, d2_yb, top, top + 10'd120); end
      checks++; if (d2_score !== 8'd1) begin failures++; $display("FAIL score_respawn got=%0d exp=1", d2_score); end
      wait_x(10'd200, 1200, ok);
      wait_move(4, lb);
      checks++; if (d2_score !== 8'd2) begin failures++; $display("FAIL score_second got=%0d exp=2", d2_score); end
      wait_x(10'd150, 200, ok);
      checks++; if (d2_score !== 8'd2) begin failures++; $display("FAIL score_once_per_pipe got=%0d exp=2", d2_score); end
   endtask

   task automatic test_freeze();
      logic [15:0] lb;
      logic [9:0]  xf;
      wait_move(4, lb);
      cyc();
      xf = d2_xr;
      Q_Lose = 1'b1;
      cyc();
      Q_Lose = 1'b0;
      checks++; if (d2_xr !== xf) begin failures++; $display("FAIL lose_on_tick got=%0d exp=%0d", d2_xr, xf); end
      cyc(); cyc(); cyc();
      checks++; if (d2_xr !== xf || d2_valid !== 1'b1) begin failures++; $display("FAIL frozen_hold got=%0d exp=%0d", d2_xr, xf); end
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      checks++; if (d2_xr !== xf || d2_score !== 8'd2) begin failures++; $display("FAIL start_in_frozen got=x%0d/s%0d exp=x%0d/s2", d2_xr, d2_score, xf); end
      Ack = 1'b1;
      cyc();
      Ack = 1'b0;
      checks++; if (d2_valid !== 1'b0) begin failures++; $display("FAIL ack_valid got=%0b exp=0", d2_valid); end
      checks++; if (d2_xr !== 10'd0 || d2_xl !== 10'd0 || d2_yt !== 10'd0 || d2_yb !== 10'd0) begin failures++; $display("FAIL ack_edges got=%0d/%0d/%0d/%0d exp=0", d2_xl, d2_xr, d2_yt, d2_yb); end
      checks++; if (d2_score !== 8'd2) begin failures++; $display("FAIL ack_score_held got=%0d exp=2", d2_score); end
      Start = 1'b1;
      cyc();
      Start = 1'b0;
      checks++; if (d2_score !== 8'd0 || d2_xr !== 10'd700 || d2_valid !== 1'b1) begin failures++; $display("FAIL restart got=s%0d/x%0d/v%0b exp=s0/x700/v1", d2_score, d2_xr, d2_valid); end
   endtask

`ifdef PIPE_SPEEDUP_EN
   task automatic test_speedup();
      logic [15:0] lb;
      logic [9:0]  xs;
      force dut2.Score = 8'd8;
      wait_move(4, lb);
      xs = d2_xr;
      wait_move(4, lb);
      checks++; if (d2_xr !== xs - 10'd2) begin failures++; $display("FAIL speedup_8 got=%0d exp=%0d", d2_xr, xs - 10'd2); end
      force dut2.Score = 8'd24;
      wait_move(4, lb);
      xs = d2_xr;
      wait_move(4, lb);
      checks++; if (d2_xr !== xs - 10'd4) begin failures++; $display("FAIL speedup_24 got=%0d exp=%0d", d2_xr, xs - 10'd4); end
      release dut2.Score;
   endtask
`endif

   task automatic test_reset_midgame();
      reset = 1'b1; Start = 1'b1;
      cyc();
      reset = 1'b0; Start = 1'b0;
      checks++; if (d2_valid !== 1'b0 || d2_xr !== 10'd0 || d2_score !== 8'd0) begin failures++; $display("FAIL midgame_reset got=v%0b/x%0d/s%0d exp=v0/x0/s0", d2_valid, d2_xr, d2_score); end
      cyc();
      checks++; if (d2_valid !== 1'b0 || d4_valid !== 1'b0) begin failures++; $display("FAIL reset_start_ignored got=%0b/%0b exp=0/0", d2_valid, d4_valid); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_spawn();
      test_ignored_in_scroll();
      test_score_and_edges();
      test_freeze();
`ifdef PIPE_SPEEDUP_EN
      test_speedup();
`endif
      test_reset_midgame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
